// File: rtl/tm1638_led_key_rsp_if.sv
// TM1638 3-wire bus bundle (STB/CLK/DIO split into MOSI/MISO plus drive enable).
// master = host side, slave = responder side.
interface tm1638_led_key_rsp_if;
    logic SCLK_i;
    logic SS_i;
    logic MOSI_i;
    logic MISO_o;
    logic MISO_EN_o;

    modport master (output SCLK_i, SS_i, MOSI_i, input MISO_o, MISO_EN_o);
    modport slave  (input SCLK_i, SS_i, MOSI_i, output MISO_o, MISO_EN_o);
endinterface

// File: rtl/tm1638_led_key_rsp.sv
// TM1638 device-side responder: decodes host commands into a 16-byte display
// RAM plus display control and returns a 4-byte key snapshot on reads.
// Optional macro TM1638_RSP_GLITCH_FILTER_EN: SCLK/SS must hold for three
// consecutive synchronized samples before an edge is taken (+2 CK latency).
module tm1638_led_key_rsp #(
    parameter int C_SYNC_STAGES = 2
) (
    input  logic                 CK_i,
    input  logic                 XARST_i,
    tm1638_led_key_rsp_if.slave  bus,
    input  logic [7:0]           KEYS_i,
    output logic [127:0]         GRID_RAM_o,
    output logic                 DISP_ON_o,
    output logic [2:0]           BRIGHT_o,
    output logic                 UPD_o,
    output logic                 CMD_ERR_o
);
    typedef enum logic [2:0] {S_IDLE, S_CMD, S_WDATA, S_IGNORE, S_RKEY} state_t;

    // Key byte n carries key 7-2n in bit 0 and key 6-2n in bit 4.
    function automatic logic [31:0] key_word(input logic [7:0] k);
        logic [31:0] w;
        w = '0;
        for (int n = 0; n < 4; n++) begin
            w[8*n]     = k[7-2*n];
            w[8*n + 4] = k[6-2*n];
        end
        return w;
    endfunction

    logic [C_SYNC_STAGES-1:0] sclk_sync, ss_sync, mosi_sync;
    logic sclk_s, ss_s, mosi_s;
    logic sclk_q, ss_q;
    logic sclk_ok, ss_ok;
    logic sclk_rise, sclk_fall, ss_rise, ss_fall;

    // Bus pins into the clock domain; bus idles with SCLK and SS high.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            sclk_sync <= '1;
            ss_sync   <= '1;
            mosi_sync <= '0;
        end else begin
            sclk_sync <= {sclk_sync[C_SYNC_STAGES-2:0], bus.SCLK_i};
            ss_sync   <= {ss_sync[C_SYNC_STAGES-2:0],   bus.SS_i};
            mosi_sync <= {mosi_sync[C_SYNC_STAGES-2:0], bus.MOSI_i};
        end
    end

    assign sclk_s = sclk_sync[C_SYNC_STAGES-1];
    assign ss_s   = ss_sync[C_SYNC_STAGES-1];
    assign mosi_s = mosi_sync[C_SYNC_STAGES-1];

`ifdef TM1638_RSP_GLITCH_FILTER_EN
    logic [1:0] sclk_hist, ss_hist;

    // Two-sample history; a level is accepted once three samples agree.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            sclk_hist <= 2'b11;
            ss_hist   <= 2'b11;
        end else begin
            sclk_hist <= {sclk_hist[0], sclk_s};
            ss_hist   <= {ss_hist[0], ss_s};
        end
    end

    assign sclk_ok = (sclk_hist == {2{sclk_s}});
    assign ss_ok   = (ss_hist == {2{ss_s}});
`else
    assign sclk_ok = 1'b1;
    assign ss_ok   = 1'b1;
`endif

    // Accepted level copy; edges are taken where the accepted level changes.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            sclk_q <= 1'b1;
            ss_q   <= 1'b1;
        end else begin
            if (sclk_ok) sclk_q <= sclk_s;
            if (ss_ok)   ss_q   <= ss_s;
        end
    end

    assign sclk_rise = sclk_ok &  sclk_s & ~sclk_q;
    assign sclk_fall = sclk_ok & ~sclk_s &  sclk_q;
    assign ss_rise   = ss_ok   &  ss_s   & ~ss_q;
    assign ss_fall   = ss_ok   & ~ss_s   &  ss_q;

    state_t          state, state_nxt;
    logic [2:0]      bit_cnt;
    logic [7:0]      shreg, byte_val;
    logic [3:0]      addr;
    logic            fixed_mode;
    logic [15:0][7:0] ram;
    logic            disp_on;
    logic [2:0]      bright;
    logic            dirty, upd, cmd_err, miso_en, skip_fall;
    logic [31:0]     key_sr;
    logic            shift_en, ram_we, ctrl_we, mode_we, addr_we, err, key_load;

    // State register.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) state <= S_IDLE;
        else          state <= state_nxt;
    end

    // Next state plus one-cycle strobes for the datapath.
    always_comb begin
        state_nxt = state;
        byte_val  = {mosi_s, shreg[7:1]};
        shift_en  = 1'b0;
        ram_we    = 1'b0;
        ctrl_we   = 1'b0;
        mode_we   = 1'b0;
        addr_we   = 1'b0;
        err       = 1'b0;
        key_load  = 1'b0;
        if (ss_rise) begin
            state_nxt = S_IDLE;
        end else if (ss_fall) begin
            state_nxt = S_CMD;
        end else if (sclk_rise && state != S_IDLE && state != S_RKEY) begin
            shift_en = 1'b1;
            if (bit_cnt == 3'd7) begin
                unique case (state)
                    S_CMD: begin
                        unique case (byte_val[7:6])
                            2'b01: begin
                                mode_we   = 1'b1;
                                key_load  = byte_val[1];
                                state_nxt = byte_val[1] ? S_RKEY : S_IGNORE;
                            end
                            2'b11: begin
                                addr_we   = 1'b1;
                                state_nxt = S_WDATA;
                            end
                            2'b10: begin
                                ctrl_we   = 1'b1;
                                state_nxt = S_IGNORE;
                            end
                            default: begin
                                err       = 1'b1;
                                state_nxt = S_IGNORE;
                            end
                        endcase
                    end
                    S_WDATA: ram_we = 1'b1;
                    default: ;
                endcase
            end
        end
    end

    // Byte assembly, RAM/control writes, key readout and status pulses.
    always_ff @(posedge CK_i or negedge XARST_i) begin
        if (!XARST_i) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            addr       <= '0;
            fixed_mode <= 1'b0;
            ram        <= '0;
            disp_on    <= 1'b0;
            bright     <= '0;
            dirty      <= 1'b0;
            upd        <= 1'b0;
            cmd_err    <= 1'b0;
            miso_en    <= 1'b0;
            skip_fall  <= 1'b0;
            key_sr     <= '0;
        end else begin
            upd     <= ss_rise & dirty;
            cmd_err <= err;
            if (ss_fall) begin
                bit_cnt <= '0;
                shreg   <= '0;
                dirty   <= 1'b0;
                miso_en <= 1'b0;
            end else if (ss_rise) begin
                dirty   <= 1'b0;
                miso_en <= 1'b0;
            end else if (shift_en) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= byte_val;
            end
            if (mode_we) fixed_mode <= byte_val[2];
            if (addr_we) addr <= byte_val[3:0];
            if (ram_we) begin
                ram[addr] <= byte_val;
                if (!fixed_mode) addr <= addr + 4'd1;
                dirty <= 1'b1;
            end
            if (ctrl_we) begin
                disp_on <= byte_val[3];
                bright  <= byte_val[2:0];
                dirty   <= 1'b1;
            end
            // The fall closing the command byte must not consume bit 0.
            if (key_load) begin
                key_sr    <= key_word(KEYS_i);
                miso_en   <= 1'b1;
                skip_fall <= 1'b1;
            end else if (state == S_RKEY && sclk_fall && !ss_rise) begin
                if (skip_fall) skip_fall <= 1'b0;
                else           key_sr    <= {1'b0, key_sr[31:1]};
            end
        end
    end

    assign bus.MISO_o    = miso_en & key_sr[0];
    assign bus.MISO_EN_o = miso_en;
    assign GRID_RAM_o    = ram;
    assign DISP_ON_o     = disp_on;
    assign BRIGHT_o      = bright;
    assign UPD_o         = upd;
    assign CMD_ERR_o     = cmd_err;
endmodule

// File: tb/tb_tm1638_led_key_rsp.sv
// Randomized bench for tm1638_led_key_rsp with a transaction-level model.
module tb_tm1638_led_key_rsp;
    logic         CK_i = 1'b0;
    logic         XARST_i = 1'b0;
    logic [7:0]   KEYS_i = '0;
    logic [127:0] GRID_RAM_o;
    logic         DISP_ON_o;
    logic [2:0]   BRIGHT_o;
    logic         UPD_o;
    logic         CMD_ERR_o;

    tm1638_led_key_rsp_if bus ();

    tm1638_led_key_rsp dut (
        .CK_i       (CK_i),
        .XARST_i    (XARST_i),
        .bus        (bus),
        .KEYS_i     (KEYS_i),
        .GRID_RAM_o (GRID_RAM_o),
        .DISP_ON_o  (DISP_ON_o),
        .BRIGHT_o   (BRIGHT_o),
        .UPD_o      (UPD_o),
        .CMD_ERR_o  (CMD_ERR_o)
    );

    always #5 CK_i = ~CK_i;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: phase -1 idle, 0 command byte, 1 data write, 2 ignore, 3 key read.
    logic [7:0]  m_ram [16];
    int          m_addr, m_phase, m_upd, m_err;
    bit          m_fixed, m_disp, m_dirty;
    logic [2:0]  m_bright;
    logic [31:0] m_keys;
    bit          chk_en = 1'b0;
    int          upd_seen = 0, err_seen = 0;

    function automatic logic [31:0] keys_to_word(input logic [7:0] k);
        logic [31:0] w = 0;
        for (int n = 0; n < 4; n++)
            w = w + (32'(k[7-2*n]) << (8*n)) + (32'(k[6-2*n]) << (8*n + 4));
        return w;
    endfunction

    function automatic logic [127:0] m_grid();
        logic [127:0] v = '0;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = m_ram[k];
        return v;
    endfunction

    function automatic void m_reset();
        for (int k = 0; k < 16; k++) m_ram[k] = 8'h00;
        m_addr = 0; m_phase = -1; m_fixed = 0; m_disp = 0; m_bright = 0; m_dirty = 0;
    endfunction

    function automatic void m_byte(input logic [7:0] b);
        case (m_phase)
            0: begin
                if (b[7:6] == 2'b01) begin
                    m_fixed = b[2];
                    m_phase = b[1] ? 3 : 2;
                    if (b[1]) m_keys = keys_to_word(KEYS_i);
                end else if (b[7:6] == 2'b11) begin
                    m_addr = int'(b[3:0]); m_phase = 1;
                end else if (b[7:6] == 2'b10) begin
                    m_disp = b[3]; m_bright = b[2:0]; m_dirty = 1; m_phase = 2;
                end else begin
                    m_err++; m_phase = 2;
                end
            end
            1: begin
                m_ram[m_addr] = b; m_dirty = 1;
                if (!m_fixed) m_addr = (m_addr + 1) % 16;
            end
            default: ;
        endcase
    endfunction

    // Continuous check of the architectural outputs against the model.
    always @(negedge CK_i) begin
        if (chk_en)
            chk("outputs", {GRID_RAM_o, DISP_ON_o, BRIGHT_o, bus.MISO_EN_o},
                {m_grid(), m_disp, m_bright, 1'(m_phase == 3)});
    end

    // Count pulse cycles so a one-cycle pulse counts exactly once.
    always @(negedge CK_i) begin
        if (UPD_o)     upd_seen++;
        if (CMD_ERR_o) err_seen++;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CK_i);
        #1;
    endtask

    task automatic ss_fall();
        bus.SS_i = 1'b0;
        m_phase = 0; m_dirty = 0;
        tick(10);
    endtask

    task automatic ss_rise();
        chk_en = 1'b0;
        bus.SS_i = 1'b1;
        tick(12);
        if (m_dirty) m_upd++;
        m_dirty = 0; m_phase = -1;
        chk_en = 1'b1;
        chk("upd_count", 160'(upd_seen), 160'(m_upd));
        chk("err_count", 160'(err_seen), 160'(m_err));
    endtask

    task automatic send_bits(input logic [7:0] b, input int n, input bit glitch);
        chk_en = 1'b0;
        for (int i = 0; i < n; i++) begin
            bus.SCLK_i = 1'b0; bus.MOSI_i = b[i];
            tick(8);
            bus.SCLK_i = 1'b1;
            if (glitch && i == 3) begin
                tick(4); bus.SCLK_i = 1'b0; tick(1); bus.SCLK_i = 1'b1; tick(3);
            end else begin
                tick(8);
            end
        end
        if (n == 8) m_byte(b);
        chk_en = 1'b1;
    endtask

    task automatic send(input logic [7:0] b);
        send_bits(b, 8, 1'b0);
    endtask

    task automatic read_keys(input bit change, output logic [31:0] got);
        got = '0;
        for (int i = 0; i < 32; i++) begin
            bus.SCLK_i = 1'b0;
            tick(8);
            got[i] = bus.MISO_o;
            if (change && i == 12) KEYS_i = 8'($urandom);
            bus.SCLK_i = 1'b1;
            tick(8);
        end
        chk("miso_after_32", 160'(bus.MISO_o), 160'(0));
    endtask

    logic [31:0] kw;
    int          u0, e0, r, n;

    initial begin
        bus.SCLK_i = 1'b1; bus.SS_i = 1'b1; bus.MOSI_i = 1'b0;
        m_upd = 0; m_err = 0; m_keys = 0;
        m_reset();
        tick(3);
        chk("reset_state", {GRID_RAM_o, DISP_ON_o, BRIGHT_o, bus.MISO_o, bus.MISO_EN_o, UPD_o, CMD_ERR_o}, '0);
        XARST_i = 1'b1;
        tick(6);
        chk_en = 1'b1;

        // Write burst.
        u0 = upd_seen;
        ss_fall(); send(8'h40); ss_rise();
        chk("burst_no_upd_mode", 160'(upd_seen - u0), 160'(0));
        ss_fall(); send(8'hC0); send(8'h3F); send(8'h01); send(8'h06); send(8'h00); ss_rise();
        chk("burst_ram", 160'(GRID_RAM_o[31:0]), 160'(32'h0006013F));
        chk("burst_upd", 160'(upd_seen - u0), 160'(1));

        // Fixed address, then auto with wrap.
        ss_fall(); send(8'h44); ss_rise();
        ss_fall(); send(8'hC5); send(8'hAA); send(8'h55); ss_rise();
        chk("fixed_ram5", 160'(GRID_RAM_o[47:40]), 160'(8'h55));
        chk("fixed_ram6", 160'(GRID_RAM_o[55:48]), 160'(8'h00));
        ss_fall(); send(8'h40); ss_rise();
        ss_fall(); send(8'hCF); send(8'h11); send(8'h22); ss_rise();
        chk("wrap_ram15", 160'(GRID_RAM_o[127:120]), 160'(8'h11));
        chk("wrap_ram0", 160'(GRID_RAM_o[7:0]), 160'(8'h22));

        // Display control.
        u0 = upd_seen;
        ss_fall(); send(8'h8C); ss_rise();
        chk("disp_on", {DISP_ON_o, BRIGHT_o}, {1'b1, 3'd4});
        chk("disp_upd", 160'(upd_seen - u0), 160'(1));
        ss_fall(); send(8'h80); ss_rise();
        chk("disp_off", {DISP_ON_o, BRIGHT_o}, {1'b0, 3'd0});

        // Key read, static and with keys changing mid-read.
        KEYS_i = 8'hA5;
        ss_fall(); send(8'h42); read_keys(1'b0, kw); ss_rise();
        chk("keys_a5", 160'(kw), 160'(32'h10100101));
        KEYS_i = 8'hA5;
        ss_fall(); send(8'h42); read_keys(1'b1, kw); ss_rise();
        chk("keys_a5_change", 160'(kw), 160'(32'h10100101));
        chk("miso_en_idle", 160'(bus.MISO_EN_o), 160'(0));

        // Aborted byte, illegal command.
        ss_fall(); send_bits(8'hC3, 5, 1'b0); ss_rise();
        e0 = err_seen;
        ss_fall(); send(8'h3A); send(8'hC1); send(8'h77); ss_rise();
        chk("illegal_err", 160'(err_seen - e0), 160'(1));

`ifdef TM1638_RSP_GLITCH_FILTER_EN
        ss_fall(); send(8'hC7); send_bits(8'h5A, 8, 1'b1); ss_rise();
        chk("glitch_ram7", 160'(GRID_RAM_o[63:56]), 160'(8'h5A));
`endif

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            r = $urandom_range(0, 5);
            case (r)
                0: begin
                    ss_fall(); send(8'h40 | 8'($urandom_range(0, 1) << 2));
                    n = $urandom_range(0, 2);
                    for (int i = 0; i < n; i++) send(8'($urandom));
                    ss_rise();
                end
                1: begin
                    ss_fall(); send(8'hC0 | 8'($urandom_range(0, 15)));
                    n = $urandom_range(0, 4);
                    for (int i = 0; i < n; i++) send(8'($urandom));
                    ss_rise();
                end
                2: begin
                    ss_fall(); send(8'h80 | 8'($urandom_range(0, 15))); ss_rise();
                end
                3: begin
                    KEYS_i = 8'($urandom);
                    ss_fall(); send(8'h42); read_keys(1'($urandom), kw); ss_rise();
                    chk("keys_rand", 160'(kw), 160'(m_keys));
                end
                4: begin
                    ss_fall(); send(8'($urandom_range(0, 63)));
                    send(8'($urandom)); ss_rise();
                end
                default: begin
                    ss_fall(); send(8'hC0 | 8'($urandom_range(0, 15)));
                    send_bits(8'($urandom), $urandom_range(1, 7), 1'b0); ss_rise();
                end
            endcase
        end

        // Reset in the middle of a burst.
        ss_fall(); send(8'hC2); send(8'h12);
        chk_en = 1'b0;
        bus.SCLK_i = 1'b0; bus.MOSI_i = 1'b1; tick(4);
        XARST_i = 1'b0;
        tick(2);
        chk("midreset_grid", {GRID_RAM_o, DISP_ON_o, BRIGHT_o, bus.MISO_EN_o}, '0);
        bus.SCLK_i = 1'b1; bus.SS_i = 1'b1;
        tick(3);
        XARST_i = 1'b1;
        m_reset(); m_phase = -1;
        tick(8);
        chk_en = 1'b1;
        ss_fall(); send(8'hC3); send(8'h9E); ss_rise();
        chk("after_reset_write", 160'(GRID_RAM_o[31:24]), 160'(8'h9E));

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
